icosoc_mod_pulsegen: RTL and testbench
======================================

Name: icosoc_mod_pulsegen

Overview:
- icosoc peripheral that drives one output pin with a programmable pulse train.
- Counterpart to the external-interrupt input module: this block generates pin events rather than detecting them.
- Configured over the standard icosoc ctrl bus.
- Raises a one-cycle ctrl_irq when a finite burst completes.

Parameters:
CLOCK_FREQ_HZ, 0, system clock frequency; unused, kept for uniform module instantiation.
CNT_BITS, 16, width of the phase-length and pulse-count registers (1..32).

Ports:
clk  input  1  system clock
resetn  input  1  synchronous active-low reset
ctrl_wr  input  1  register write request, held until ctrl_done
ctrl_rd  input  1  register read request, held until ctrl_done
ctrl_addr  input  8  register byte address
ctrl_wdat  input  32  write data
ctrl_rdat  output  32  read data, valid only while ctrl_done=1
ctrl_done  output  1  one-cycle access acknowledge
ctrl_irq  output  1  one-cycle burst-complete interrupt
pin  output  1  pulse output, via SB_IO with registered output (PIN_TYPE 0101_01)

Behaviour:
- Clocking and reset: single clock clk. Reset is synchronous, active-low, on resetn.
- Reset values: all registers 0; FSM IDLE; pin=0; ctrl_done=0; ctrl_irq=0.
- Bus handshake: a request seen while ctrl_done=0 is accepted. ctrl_done=1 on the next cycle for exactly one cycle. No access is accepted in the ctrl_done cycle. Unmapped addresses ack, ignore writes, read 0.
- Register map (CNT_BITS fields zero-extended on read, upper write bits ignored):
  - 0x00 CTRL: [0] start/busy, [1] idle level POL, [2] IRQEN, [3] CONT (continuous).
  - 0x04 HIGH: active-phase length in cycles.
  - 0x08 LOW: inactive-phase length in cycles.
  - 0x0C COUNT: pulses per burst.
  - 0x10 REMAIN: pulses not yet started (read-only).
- Active level is !POL. Idle level is POL. HIGH or LOW value 0 is treated as 1.
- FSM states: IDLE, ACTIVE, INACTIVE.
  - IDLE: pin=POL. Entered on reset, abort, or completion.
  - Start: a write to CTRL with [0]=1 takes effect on the edge that sets ctrl_done.
    - COUNT=0 and CONT=0: stay IDLE; ctrl_irq=1 next cycle if IRQEN.
    - Otherwise: REMAIN<=COUNT-1, phase counter <= HIGH, enter ACTIVE, pin=!POL on the same edge.
  - ACTIVE: counter decrements each cycle. At 1, load LOW and enter INACTIVE; pin=POL.
  - INACTIVE: counter decrements each cycle. At 1:
    - CONT=1 or REMAIN>0: decrement REMAIN (saturate at 0 when CONT=1), load HIGH, enter ACTIVE.
    - Otherwise: enter IDLE; ctrl_irq=1 for one cycle if IRQEN.
- Pulse timing: pin is active exactly max(HIGH,1) cycles and inactive max(LOW,1) cycles per pulse. Burst duration = COUNT*(max(HIGH,1)+max(LOW,1)) cycles.
- Mid-burst register writes: writing HIGH, LOW or COUNT while busy takes effect at the next phase load. REMAIN is not reloaded.
- Mid-burst CTRL writes:
  - [0]=1: restart from pulse 1.
  - [0]=0: abort; IDLE next edge, pin=POL, no irq.
  - POL change applies immediately to the pin level.
  - Clearing CONT ends the burst after the current pulse if REMAIN=0.
- CTRL[0] read returns busy (FSM != IDLE), not the written value.
- resetn low mid-burst: IDLE, pin=0, no irq, on that edge.

Optional Feature:
PULSEGEN_READBACK_EN
- Defined: HIGH, LOW, COUNT and REMAIN are readable as specified.
- Undefined: reads of 0x04–0x10 return 0. CTRL readback and all pulse behaviour are unchanged.

Test Plan:
- Reset, then read CTRL -> 0x0; pin=0; ctrl_irq never asserted.
- HIGH=3, LOW=2, COUNT=4, CTRL=0x5 -> pin high 3 / low 2 cycles, 4 times (20 cycles); one ctrl_irq pulse on the completing edge; CTRL reads 0x4 afterwards.
- HIGH=0, LOW=0, COUNT=2, POL=1 -> pin low 1, high 1, low 1, high 1; irq only if IRQEN; pin stays 1 after.
- CONT=1, HIGH=5, LOW=5, start; after 37 cycles write CTRL=0 -> pin returns to idle on the next edge; no irq; REMAIN=0.
- COUNT=0, CTRL=0x5 -> pin never toggles; ctrl_irq pulses once, one cycle after ctrl_done.
- Readback: COUNT=10 started, HIGH=LOW=1, read REMAIN after 4 full pulses -> 5 with PULSEGEN_READBACK_EN, 0 without.

Source files
------------

// File: rtl/icosoc_mod_pulsegen_if.sv
// icosoc ctrl bus seen from a peripheral: held request, one-cycle acknowledge,
// read data and the peripheral interrupt line.
interface icosoc_mod_pulsegen_if;
  logic        ctrl_wr;
  logic        ctrl_rd;
  logic [7:0]  ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;
  logic        ctrl_irq;

  modport master (
    output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
    input  ctrl_rdat, ctrl_done, ctrl_irq
  );

  modport slave (
    input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
    output ctrl_rdat, ctrl_done, ctrl_irq
  );
endinterface

// File: rtl/icosoc_mod_pulsegen.sv
// icosoc pulse-train generator: one output pin, HIGH/LOW phase lengths, finite or continuous bursts.
// Optional macro PULSEGEN_READBACK_EN enables readback of HIGH, LOW, COUNT and REMAIN.
module icosoc_mod_pulsegen #(
  parameter int CLOCK_FREQ_HZ = 0,
  parameter int CNT_BITS      = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  icosoc_mod_pulsegen_if.slave  bus,
  output logic                  pin
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, INACTIVE = 2'd2} state_t;
  typedef logic [CNT_BITS-1:0] cnt_t;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_HIGH   = 8'h04;
  localparam logic [7:0] ADDR_LOW    = 8'h08;
  localparam logic [7:0] ADDR_COUNT  = 8'h0C;
  localparam logic [7:0] ADDR_REMAIN = 8'h10;

  state_t      state_r, state_s;
  cnt_t        cnt_r, cnt_s, remain_r, remain_s;
  cnt_t        high_r, high_s, low_r, low_s, count_r, count_s;
  logic        pol_r, pol_s, irqen_r, irqen_s, cont_r, cont_s;
  logic        zirq_r, zirq_s;
  logic        irq_r, irq_s, done_r, pin_r, pin_s;
  logic [31:0] rdat_r, rdat_s;
  logic        acc_s, wr_s, wr_ctrl_s;
  logic        unused_s;

  function automatic cnt_t at_least_one(input cnt_t v);
    return (v == '0) ? cnt_t'(1'b1) : v;
  endfunction

  function automatic logic [31:0] zext(input cnt_t v);
    logic [31:0] r;
    r = 32'd0;
    r[CNT_BITS-1:0] = v;
    return r;
  endfunction

  // Read-data mux, sampled on the accepting edge
  always_comb begin
    rdat_s = 32'd0;
    case (bus.ctrl_addr)
      ADDR_CTRL:   rdat_s = {28'd0, cont_r, irqen_r, pol_r, state_r != IDLE};
`ifdef PULSEGEN_READBACK_EN
      ADDR_HIGH:   rdat_s = zext(high_r);
      ADDR_LOW:    rdat_s = zext(low_r);
      ADDR_COUNT:  rdat_s = zext(count_r);
      ADDR_REMAIN: rdat_s = zext(remain_r);
`else
      ADDR_HIGH, ADDR_LOW, ADDR_COUNT, ADDR_REMAIN: rdat_s = 32'd0;
`endif
      default:     rdat_s = 32'd0;
    endcase
  end

  // Bus decode, register updates and pulse FSM next state
  always_comb begin
    acc_s     = (bus.ctrl_wr | bus.ctrl_rd) & ~done_r;
    wr_s      = acc_s & bus.ctrl_wr;
    wr_ctrl_s = wr_s && (bus.ctrl_addr == ADDR_CTRL);
    high_s    = (wr_s && bus.ctrl_addr == ADDR_HIGH)  ? bus.ctrl_wdat[CNT_BITS-1:0] : high_r;
    low_s     = (wr_s && bus.ctrl_addr == ADDR_LOW)   ? bus.ctrl_wdat[CNT_BITS-1:0] : low_r;
    count_s   = (wr_s && bus.ctrl_addr == ADDR_COUNT) ? bus.ctrl_wdat[CNT_BITS-1:0] : count_r;
    pol_s     = wr_ctrl_s ? bus.ctrl_wdat[1] : pol_r;
    irqen_s   = wr_ctrl_s ? bus.ctrl_wdat[2] : irqen_r;
    cont_s    = wr_ctrl_s ? bus.ctrl_wdat[3] : cont_r;
    state_s   = state_r;
    cnt_s     = cnt_r;
    remain_s  = remain_r;
    irq_s     = zirq_r;
    zirq_s    = 1'b0;

    case (state_r)
      IDLE: state_s = IDLE;
      ACTIVE: begin
        if (cnt_r <= cnt_t'(1'b1)) begin
          state_s = INACTIVE;
          cnt_s   = at_least_one(low_r);
        end else begin
          cnt_s = cnt_r - cnt_t'(1'b1);
        end
      end
      INACTIVE: begin
        if (cnt_r <= cnt_t'(1'b1)) begin
          if (cont_r || remain_r != '0) begin
            state_s  = ACTIVE;
            cnt_s    = at_least_one(high_r);
            remain_s = (remain_r != '0) ? remain_r - cnt_t'(1'b1) : '0;
          end else begin
            state_s = IDLE;
            irq_s   = irqen_r;
          end
        end else begin
          cnt_s = cnt_r - cnt_t'(1'b1);
        end
      end
      default: state_s = IDLE;
    endcase

    // A CTRL write overrides the running burst: restart, abort, or empty-burst irq
    if (wr_ctrl_s) begin
      irq_s = zirq_r;
      if (bus.ctrl_wdat[0] && count_r == '0 && !bus.ctrl_wdat[3]) begin
        state_s = IDLE;
        zirq_s  = bus.ctrl_wdat[2];
      end else if (bus.ctrl_wdat[0]) begin
        state_s  = ACTIVE;
        cnt_s    = at_least_one(high_r);
        remain_s = (count_r != '0) ? count_r - cnt_t'(1'b1) : '0;
      end else begin
        state_s = IDLE;
      end
    end else begin
      zirq_s = 1'b0;
    end

    pin_s = (state_s == ACTIVE) ? ~pol_s : pol_s;
  end

  // State and output registers; pin_r stands in for the SB_IO output register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      remain_r <= '0;
      high_r   <= '0;
      low_r    <= '0;
      count_r  <= '0;
      pol_r    <= 1'b0;
      irqen_r  <= 1'b0;
      cont_r   <= 1'b0;
      zirq_r   <= 1'b0;
      irq_r    <= 1'b0;
      done_r   <= 1'b0;
      pin_r    <= 1'b0;
      rdat_r   <= 32'd0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      remain_r <= remain_s;
      high_r   <= high_s;
      low_r    <= low_s;
      count_r  <= count_s;
      pol_r    <= pol_s;
      irqen_r  <= irqen_s;
      cont_r   <= cont_s;
      zirq_r   <= zirq_s;
      irq_r    <= irq_s;
      done_r   <= acc_s;
      pin_r    <= pin_s;
      rdat_r   <= acc_s ? rdat_s : 32'd0;
    end
  end

  assign bus.ctrl_done = done_r;
  assign bus.ctrl_rdat = rdat_r;
  assign bus.ctrl_irq  = irq_r;
  assign pin           = pin_r;

  // Upper write-data bits and the clock parameter have no function here
  assign unused_s = ^{bus.ctrl_wdat, (CLOCK_FREQ_HZ != 0)};
endmodule

// File: tb/tb_icosoc_mod_pulsegen.sv
// Directed bench for icosoc_mod_pulsegen: bus handshake, burst timing, continuous mode,
// abort, empty burst, readback and reset.
module tb_icosoc_mod_pulsegen;
  logic clk = 1'b0;
  logic resetn;
  logic pin;
  int   n_total = 0;
  int   n_bad   = 0;
  int   irq_cnt = 0;

  icosoc_mod_pulsegen_if bus ();

  icosoc_mod_pulsegen #(.CLOCK_FREQ_HZ(0), .CNT_BITS(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .pin    (pin)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ctrl_irq === 1'b1) irq_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdat,
                          output logic [31:0] rdat);
    int n;
    if (bus.ctrl_done === 1'b1) step();
    bus.ctrl_addr = addr;
    bus.ctrl_wdat = wdat;
    bus.ctrl_wr   = wr;
    bus.ctrl_rd   = ~wr;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.ctrl_done !== 1'b1 && n < 10);
    check("bus_ack", 32'(bus.ctrl_done), 32'd1);
    rdat = bus.ctrl_rdat;
    bus.ctrl_wr = 1'b0;
    bus.ctrl_rd = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] wdat);
    logic [31:0] d;
    bus_xfer(1'b1, addr, wdat, d);
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] d);
    bus_xfer(1'b0, addr, 32'd0, d);
  endtask

  initial begin
    logic [31:0] d;
    int          base;
    logic [5:0]  b2_pin;
    logic [31:0] exp_remain, exp_count, exp_high;

    bus.ctrl_wr = 1'b0;
    bus.ctrl_rd = 1'b0;
    bus.ctrl_addr = 8'h00;
    bus.ctrl_wdat = 32'd0;
    resetn = 1'b0;
    repeat (3) step();
    check("rst_pin", 32'(pin), 32'd0);
    check("rst_done", 32'(bus.ctrl_done), 32'd0);
    check("rst_irq", 32'(bus.ctrl_irq), 32'd0);
    resetn = 1'b1;
    step();
    rd(8'h00, d);
    check("rst_ctrl", d, 32'd0);
    check("rst_irq_cnt", 32'(irq_cnt), 32'd0);

    // A held request is not re-accepted in the acknowledge cycle
    step();
    bus.ctrl_addr = 8'h00;
    bus.ctrl_rd = 1'b1;
    step();
    check("hold_ack1", 32'(bus.ctrl_done), 32'd1);
    step();
    check("hold_gap", 32'(bus.ctrl_done), 32'd0);
    step();
    check("hold_ack2", 32'(bus.ctrl_done), 32'd1);
    bus.ctrl_rd = 1'b0;

    // Burst: HIGH=3 LOW=2 COUNT=4 IRQEN, start
    wr(8'h04, 32'd3);
    wr(8'h08, 32'd2);
    wr(8'h0C, 32'd4);
    base = irq_cnt;
    wr(8'h00, 32'h5);
    for (int k = 0; k < 22; k++) begin
      check($sformatf("b1_pin%0d", k), 32'(pin), (k < 20) ? 32'((k % 5) < 3) : 32'd0);
      check($sformatf("b1_irq%0d", k), 32'(bus.ctrl_irq), 32'(k == 20));
      step();
    end
    rd(8'h00, d);
    check("b1_ctrl", d, 32'h4);
    check("b1_irq_cnt", 32'(irq_cnt - base), 32'd1);

    // HIGH=LOW=0 behave as 1, POL=1, no IRQEN
    wr(8'h04, 32'd0);
    wr(8'h08, 32'd0);
    wr(8'h0C, 32'd2);
    base = irq_cnt;
    b2_pin = 6'b111010;
    wr(8'h00, 32'h3);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("b2_pin%0d", k), 32'(pin), 32'(b2_pin[k]));
      step();
    end
    check("b2_irq_cnt", 32'(irq_cnt - base), 32'd0);
    rd(8'h00, d);
    check("b2_ctrl", d, 32'h2);

    // Continuous 5/5, abort mid active phase
    wr(8'h04, 32'd5);
    wr(8'h08, 32'd5);
    wr(8'h0C, 32'd0);
    base = irq_cnt;
    wr(8'h00, 32'hD);
    for (int k = 0; k < 41; k++) begin
      check($sformatf("c_pin%0d", k), 32'(pin), 32'((k % 10) < 5));
      step();
    end
    wr(8'h00, 32'h0);
    check("c_abort_pin", 32'(pin), 32'd0);
    repeat (3) step();
    check("c_idle_pin", 32'(pin), 32'd0);
    rd(8'h00, d);
    check("c_ctrl", d, 32'h0);
    rd(8'h10, d);
    check("c_remain", d, 32'd0);
    check("c_irq_cnt", 32'(irq_cnt - base), 32'd0);

    // Empty burst with IRQEN: irq one cycle after ctrl_done
    base = irq_cnt;
    wr(8'h00, 32'h5);
    check("z_irq_done", 32'(bus.ctrl_irq), 32'd0);
    check("z_pin0", 32'(pin), 32'd0);
    step();
    check("z_irq_next", 32'(bus.ctrl_irq), 32'd1);
    step();
    check("z_irq_after", 32'(bus.ctrl_irq), 32'd0);
    repeat (3) step();
    check("z_pin1", 32'(pin), 32'd0);
    check("z_irq_cnt", 32'(irq_cnt - base), 32'd1);

    // Readback of REMAIN after four complete 1/1 pulses
`ifdef PULSEGEN_READBACK_EN
    exp_remain = 32'd5;
    exp_count  = 32'd10;
    exp_high   = 32'd1;
`else
    exp_remain = 32'd0;
    exp_count  = 32'd0;
    exp_high   = 32'd0;
`endif
    wr(8'h04, 32'd1);
    wr(8'h08, 32'd1);
    wr(8'h0C, 32'd10);
    base = irq_cnt;
    wr(8'h00, 32'h1);
    repeat (8) step();
    rd(8'h10, d);
    check("rb_remain", d, exp_remain);
    rd(8'h0C, d);
    check("rb_count", d, exp_count);
    rd(8'h04, d);
    check("rb_high", d, exp_high);
    rd(8'h00, d);
    check("rb_busy", d, 32'h1);
    repeat (20) step();
    rd(8'h00, d);
    check("rb_done", d, 32'h0);
    check("rb_irq_cnt", 32'(irq_cnt - base), 32'd0);

    // Unmapped address: write ignored, read zero
    wr(8'h14, 32'hFFFF_FFFF);
    rd(8'h14, d);
    check("unmap_rd", d, 32'd0);
    rd(8'h00, d);
    check("unmap_ctrl", d, 32'h0);

    // Reset in the middle of a continuous burst
    wr(8'h04, 32'd5);
    base = irq_cnt;
    wr(8'h00, 32'h9);
    step();
    check("r_pin_act", 32'(pin), 32'd1);
    resetn = 1'b0;
    step();
    check("r_pin_rst", 32'(pin), 32'd0);
    resetn = 1'b1;
    repeat (3) step();
    check("r_pin_idle", 32'(pin), 32'd0);
    rd(8'h00, d);
    check("r_ctrl", d, 32'h0);
    check("r_irq_cnt", 32'(irq_cnt - base), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
